branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Branch decision and target unit for the single-cycle RV32I core; sits beside the ALU in the execute stage.
- Evaluates the six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) on register operands and computes the PC-relative target.
- Primary outputs are combinational so the PC mux can use them in the same cycle.
- Clocked side: registered copies of the decision and target, an illegal-funct3 flag, a misaligned-target flag, and taken/seen counters for debug.

Parameters:
- XLEN, 32, data/address width.
- CNT_W, 32, width of the branch statistics counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  current instruction is a conditional branch (decoder).
- funct3  in  3  branch condition selector.
- rs1_value  in  XLEN  rs1 operand.
- rs2_value  in  XLEN  rs2 operand.
- pc_current  in  XLEN  PC of the branch instruction.
- imm  in  XLEN  sign-extended B-type immediate (byte offset).
- take_branch  out  1  combinational: redirect PC to branch_target.
- branch_target  out  XLEN  combinational: pc_current + imm.
- branch_illegal  out  1  combinational: branch=1 with reserved funct3.
- target_misaligned  out  1  combinational: take_branch=1 and branch_target[1:0] != 0.
- take_branch_q  out  1  registered take_branch.
- branch_target_q  out  XLEN  registered branch_target.
- branches_seen  out  CNT_W  count of cycles with branch=1 and legal funct3.
- branches_taken  out  CNT_W  count of cycles with take_branch=1.

Behaviour:
- funct3 decode:
  - 000 BEQ: rs1 == rs2.
  - 001 BNE: rs1 != rs2.
  - 100 BLT: signed rs1 < rs2.
  - 101 BGE: signed rs1 >= rs2.
  - 110 BLTU: unsigned rs1 < rs2.
  - 111 BGEU: unsigned rs1 >= rs2.
  - 010/011 reserved: condition false; branch_illegal = branch.
- take_branch = branch & condition; it is 0 whenever branch=0, regardless of operands.
- branch_target = pc_current + imm, modulo 2^XLEN (wrap, no overflow flag). Always driven, independent of branch.
- target_misaligned:
  - Raised only when the branch is taken (no C extension, so targets must be 4-byte aligned).
  - Does not suppress take_branch; the trap logic owns the response.
- Combinational outputs: zero latency, no dependence on clk or rst_n.
- Registered outputs update on the rising edge of clk:
  - take_branch_q / branch_target_q capture the combinational values every cycle.
  - branches_seen increments when branch=1 and funct3 is legal.
  - branches_taken increments when take_branch=1.
  - Both counters wrap from all-ones to 0 silently.
- Reset: while rst_n=0, immediately (asynchronously) force take_branch_q=0, branch_target_q=0, branches_seen=0, branches_taken=0. Reset asserted mid-operation clears these without waiting for a clock edge. The first capture occurs on the first rising edge after rst_n deasserts.
- Simultaneous events: seen and taken both increment in the same cycle for a taken legal branch.

Decomposition:
- Shared package core_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - XLEN default.
- One natural combinational sub-module: branch_cmp (operands + funct3 -> condition, illegal).
- The adder, flags and registers stay in branch_unit.

Test Plan:
- pc_current=100, imm=16, branch=1, BEQ, rs1=5, rs2=5 -> take_branch=1, branch_target=116, target_misaligned=0; next edge take_branch_q=1, branch_target_q=116.
- BEQ rs1=5, rs2=8 -> take_branch=0, target still 116.
- BNE rs1=3, rs2=2 -> take_branch=1.
- BGE rs1=3, rs2=7 -> take_branch=0.
- BLT rs1=-1 (0xFFFFFFFF), rs2=5 -> take_branch=1.
- BLTU with the same operands -> 0; BGEU -> 1.
- funct3=010, branch=1 -> take_branch=0, branch_illegal=1, branches_seen unchanged.
- branch=0, BEQ, rs1=rs2 -> take_branch=0.
- pc_current=0xFFFFFFFC, imm=8 -> branch_target=4 (wrap).
- imm=2, taken -> target_misaligned=1.
- Counters: run 3 taken and 2 not-taken legal branches -> branches_seen=5, branches_taken=3; assert rst_n=0 between edges -> all registered outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data width and RV32I branch funct3 encodings.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: compares rs1/rs2 as selected by funct3 and
// flags the two reserved funct3 encodings (010, 011).
module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    output logic            cond,
    output logic            reserved
);
    import core_pkg::*;

    logic eq_s;
    logic lt_s;
    logic ltu_s;
    logic cond_s;
    logic reserved_s;

    assign eq_s  = (rs1_value == rs2_value);
    assign lt_s  = ($signed(rs1_value) < $signed(rs2_value));
    assign ltu_s = (rs1_value < rs2_value);

    // Select the condition for the funct3 encoding; reserved encodings never branch.
    always_comb begin
        cond_s     = 1'b0;
        reserved_s = 1'b0;
        case (funct3)
            F3_BEQ:  cond_s = eq_s;
            F3_BNE:  cond_s = ~eq_s;
            F3_BLT:  cond_s = lt_s;
            F3_BGE:  cond_s = ~lt_s;
            F3_BLTU: cond_s = ltu_s;
            F3_BGEU: cond_s = ~ltu_s;
            default: begin
                cond_s     = 1'b0;
                reserved_s = 1'b1;
            end
        endcase
    end

    assign cond     = cond_s;
    assign reserved = reserved_s;

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch unit: same-cycle decision and target for the PC mux,
// plus registered copies and debug statistics counters.
module branch_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic [XLEN-1:0]  pc_current,
    input  logic [XLEN-1:0]  imm,
    output logic             take_branch,
    output logic [XLEN-1:0]  branch_target,
    output logic             branch_illegal,
    output logic             target_misaligned,
    output logic             take_branch_q,
    output logic [XLEN-1:0]  branch_target_q,
    output logic [CNT_W-1:0] branches_seen,
    output logic [CNT_W-1:0] branches_taken
);
    import core_pkg::*;

    logic             cond_s;
    logic             reserved_s;
    logic             take_s;
    logic             legal_branch_s;
    logic [XLEN-1:0]  target_s;
    logic             take_r;
    logic [XLEN-1:0]  target_r;
    logic [CNT_W-1:0] seen_r;
    logic [CNT_W-1:0] taken_r;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .funct3    (funct3),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .cond      (cond_s),
        .reserved  (reserved_s)
    );

    // Target wraps modulo 2^XLEN; it is computed even when no branch is present.
    assign target_s       = pc_current + imm;
    assign take_s         = branch & cond_s;
    assign legal_branch_s = branch & ~reserved_s;

    assign take_branch       = take_s;
    assign branch_target     = target_s;
    assign branch_illegal    = branch & reserved_s;
    // Misalignment is reported but does not veto the redirect; the trap logic decides.
    assign target_misaligned = take_s & (target_s[1:0] != 2'b00);

    // Capture decision/target every cycle and count legal and taken branches (silent wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            take_r   <= 1'b0;
            target_r <= {XLEN{1'b0}};
            seen_r   <= {CNT_W{1'b0}};
            taken_r  <= {CNT_W{1'b0}};
        end else begin
            take_r   <= take_s;
            target_r <= target_s;
            if (legal_branch_s) begin
                seen_r <= seen_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                seen_r <= seen_r;
            end
            if (take_s) begin
                taken_r <= taken_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                taken_r <= taken_r;
            end
        end
    end

    assign take_branch_q   = take_r;
    assign branch_target_q = target_r;
    assign branches_seen   = seen_r;
    assign branches_taken  = taken_r;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [2:0]  funct3;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] pc_current;
    logic [31:0] imm;
    logic        take_branch;
    logic [31:0] branch_target;
    logic        branch_illegal;
    logic        target_misaligned;
    logic        take_branch_q;
    logic [31:0] branch_target_q;
    logic [31:0] branches_seen;
    logic [31:0] branches_taken;

    branch_unit #(
        .XLEN  (32),
        .CNT_W (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .branch            (branch),
        .funct3            (funct3),
        .rs1_value         (rs1_value),
        .rs2_value         (rs2_value),
        .pc_current        (pc_current),
        .imm               (imm),
        .take_branch       (take_branch),
        .branch_target     (branch_target),
        .branch_illegal    (branch_illegal),
        .target_misaligned (target_misaligned),
        .take_branch_q     (take_branch_q),
        .branch_target_q   (branch_target_q),
        .branches_seen     (branches_seen),
        .branches_taken    (branches_taken)
    );

    typedef struct {
        logic        take;
        logic [31:0] tgt;
        logic        ill;
        logic        mis;
        logic        tq;
        logic [31:0] tgtq;
        logic [31:0] seen;
        logic [31:0] taken;
    } exp_t;

    exp_t exp_q[$];

    int checks_total  = 0;
    int checks_passed = 0;

    // Bench-side model of the registered state.
    logic        in_rst;
    logic        m_tq;
    logic [31:0] m_tgtq;
    logic [31:0] m_seen;
    logic [31:0] m_taken;
    logic        prev_take;
    logic [31:0] prev_tgt;
    logic        prev_ill;
    logic        prev_mis;
    logic        prev_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total = checks_total + 1;
        if (act === exp) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare one expectation per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("take_branch",       {31'd0, take_branch},       {31'd0, e.take});
            chk("branch_target",     branch_target,              e.tgt);
            chk("branch_illegal",    {31'd0, branch_illegal},    {31'd0, e.ill});
            chk("target_misaligned", {31'd0, target_misaligned}, {31'd0, e.mis});
            chk("take_branch_q",     {31'd0, take_branch_q},     {31'd0, e.tq});
            chk("branch_target_q",   branch_target_q,            e.tgtq);
            chk("branches_seen",     branches_seen,              e.seen);
            chk("branches_taken",    branches_taken,             e.taken);
        end
    end

    task automatic capture_edge();
        if (!in_rst) begin
            m_tq   = prev_take;
            m_tgtq = prev_tgt;
            if (prev_seen) m_seen = m_seen + 32'd1;
            if (prev_take) m_taken = m_taken + 32'd1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.take  = prev_take;
        e.tgt   = prev_tgt;
        e.ill   = prev_ill;
        e.mis   = prev_mis;
        e.tq    = m_tq;
        e.tgtq  = m_tgtq;
        e.seen  = m_seen;
        e.taken = m_taken;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [31:0] pc, input logic [31:0] im, input logic [2:0] f3,
                         input logic br, input logic [31:0] a, input logic [31:0] b,
                         input logic e_take, input logic [31:0] e_tgt,
                         input logic e_ill, input logic e_mis);
        @(posedge clk);
        capture_edge();
        #1;
        pc_current = pc;
        imm        = im;
        funct3     = f3;
        branch     = br;
        rs1_value  = a;
        rs2_value  = b;
        prev_take  = e_take;
        prev_tgt   = e_tgt;
        prev_ill   = e_ill;
        prev_mis   = e_mis;
        prev_seen  = br && (f3 != 3'b010) && (f3 != 3'b011);
        push_exp();
    endtask

    // Assert reset between edges, inputs unchanged; registered outputs must clear at once.
    task automatic reset_mid();
        @(posedge clk);
        capture_edge();
        #1;
        rst_n   = 1'b0;
        in_rst  = 1'b1;
        m_tq    = 1'b0;
        m_tgtq  = 32'd0;
        m_seen  = 32'd0;
        m_taken = 32'd0;
        #1;
        push_exp();
    endtask

    initial begin
        int budget;
        rst_n      = 1'b0;
        in_rst     = 1'b1;
        branch     = 1'b0;
        funct3     = 3'b000;
        rs1_value  = 32'd0;
        rs2_value  = 32'd0;
        pc_current = 32'd0;
        imm        = 32'd0;
        m_tq = 1'b0; m_tgtq = 32'd0; m_seen = 32'd0; m_taken = 32'd0;
        prev_take = 1'b0; prev_tgt = 32'd0; prev_ill = 1'b0; prev_mis = 1'b0; prev_seen = 1'b0;

        // Reset state with idle inputs.
        apply(32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        in_rst = 1'b0;

        //     pc            imm           f3      br    rs1           rs2     take  target        ill   mis
        apply(32'd100,      32'd16,       3'b000, 1'b1, 32'd5,        32'd5,  1'b1, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b000, 1'b1, 32'd5,        32'd8,  1'b0, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b001, 1'b1, 32'd3,        32'd2,  1'b1, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b101, 1'b1, 32'd3,        32'd7,  1'b0, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b100, 1'b1, 32'hFFFFFFFF, 32'd5,  1'b1, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b110, 1'b1, 32'hFFFFFFFF, 32'd5,  1'b0, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b111, 1'b1, 32'hFFFFFFFF, 32'd5,  1'b1, 32'd116,      1'b0, 1'b0);
        apply(32'd100,      32'd16,       3'b010, 1'b1, 32'd5,        32'd5,  1'b0, 32'd116,      1'b1, 1'b0);
        apply(32'd100,      32'd16,       3'b011, 1'b1, 32'd5,        32'd9,  1'b0, 32'd116,      1'b1, 1'b0);
        apply(32'd100,      32'd16,       3'b000, 1'b0, 32'd5,        32'd5,  1'b0, 32'd116,      1'b0, 1'b0);
        apply(32'hFFFFFFFC, 32'd8,        3'b000, 1'b1, 32'd1,        32'd1,  1'b1, 32'd4,        1'b0, 1'b0);
        apply(32'd100,      32'd2,        3'b000, 1'b1, 32'd0,        32'd0,  1'b1, 32'd102,      1'b0, 1'b1);
        apply(32'd100,      32'd2,        3'b001, 1'b1, 32'd0,        32'd0,  1'b0, 32'd102,      1'b0, 1'b0);
        apply(32'd200,      32'hFFFFFFF8, 3'b101, 1'b1, 32'd7,        32'd7,  1'b1, 32'd192,      1'b0, 1'b0);
        apply(32'd200,      32'd4,        3'b010, 1'b0, 32'd7,        32'd7,  1'b0, 32'd204,      1'b0, 1'b0);

        // Clear mid-run, hold one cycle in reset, then 3 taken + 2 not-taken legal branches.
        reset_mid();
        apply(32'd200,      32'd4,        3'b010, 1'b0, 32'd7,        32'd7,  1'b0, 32'd204,      1'b0, 1'b0);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        apply(32'd0,        32'd8,        3'b000, 1'b1, 32'd1,        32'd1,  1'b1, 32'd8,        1'b0, 1'b0);
        apply(32'd0,        32'd8,        3'b001, 1'b1, 32'd1,        32'd1,  1'b0, 32'd8,        1'b0, 1'b0);
        apply(32'd4,        32'd8,        3'b110, 1'b1, 32'd1,        32'd2,  1'b1, 32'd12,       1'b0, 1'b0);
        apply(32'd4,        32'd8,        3'b111, 1'b1, 32'd1,        32'd2,  1'b0, 32'd12,       1'b0, 1'b0);
        apply(32'd8,        32'd8,        3'b100, 1'b1, 32'hFFFFFFFE, 32'd1,  1'b1, 32'd16,       1'b0, 1'b0);
        apply(32'd8,        32'd0,        3'b000, 1'b0, 32'd0,        32'd0,  1'b0, 32'd8,        1'b0, 1'b0);
        apply(32'd8,        32'd0,        3'b000, 1'b0, 32'd0,        32'd0,  1'b0, 32'd8,        1'b0, 1'b0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget = budget + 1;
        end
        if (exp_q.size() > 0) begin
            checks_total = checks_total + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
